// File: rtl/pc_seq.sv
// ----------------------------------------------------------------------------
// pc_seq: registered program-counter sequencer for the fetch stage.
//
// It drives the instruction-memory fetch address every cycle. Sequential fetch
// advances by one word. A taken branch jumps relative to the current PC, and
// can push a return address for branch-and-link. A taken return pops the
// return-address stack (RAS). Instructions that read the PC as an operand skip
// ahead by two or three words. After a taken branch an optional FLUSH window
// holds the PC and tells downstream to squash whatever was fetched.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   stall         hold the PC (pipeline stall); freezes the FLUSH countdown
//   branch        current instruction is a branch
//   cond_pass     condition code of current instruction passes
//   link          taken branch also pushes pc+1 onto the RAS
//   ret           taken branch target is the RAS top
//   b_offset      two's-complement branch offset (target = pc + b_offset - 1)
//   rn, rm        source register indices, checked against PC_REG
//   rm_valid      rm names a real register operand
//   rs_used       instruction carries an extra shift-register word
//   pc            registered fetch address
//   flush         registered; high while in FLUSH
//   ras_count     number of valid RAS entries
//   ret_underflow sticky; a return was taken with an empty RAS
// ----------------------------------------------------------------------------
module pc_seq #(
    parameter int unsigned     AW           = 16,
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter int unsigned     FLUSH_CYCLES = 1,
    parameter logic [3:0]      PC_REG       = 4'hF,
    parameter logic [AW-1:0]   RESET_PC     = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            stall,
    input  logic                            branch,
    input  logic                            cond_pass,
    input  logic                            link,
    input  logic                            ret,
    input  logic [AW-1:0]                   b_offset,
    input  logic [3:0]                      rn,
    input  logic [3:0]                      rm,
    input  logic                            rm_valid,
    input  logic                            rs_used,
    output logic [AW-1:0]                   pc,
    output logic                            flush,
    output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
    output logic                            ret_underflow
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e            state_q;
    logic [AW-1:0]     pc_q;
    logic              flush_q;
    logic [FW-1:0]     cnt_q;
    logic [CW-1:0]     ras_count_q;
    logic              underflow_q;

    // The RAS is a circular buffer: wr_ptr_q is the next slot to write, and
    // the top of stack sits one slot below it. When full, wr_ptr_q also
    // points at the oldest entry, so a push simply overwrites it.
    logic [PW-1:0]     wr_ptr_q;
    logic [AW-1:0]     ras_mem [RAS_DEPTH];

    logic              taken;
    logic              in_run;
    logic              alias_hit;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic [PW-1:0]     ptr_inc;
    logic [PW-1:0]     ptr_dec;
    logic [AW-1:0]     ras_top;
    logic [AW-1:0]     pc_plus1;
    logic [AW-1:0]     pc_branch;
    logic [AW-1:0]     pc_alias;

    assign taken     = branch & cond_pass;
    assign in_run    = (state_q == StRun);
    assign ras_empty = (ras_count_q == '0);
    assign ras_full  = (ras_count_q == CW'(RAS_DEPTH));
    assign push      = in_run & taken & ~ret & link;

    // An instruction that reads the PC as an operand sees it ahead by the
    // words it occupies, so fetch skips past its extra words.
    assign alias_hit = ~branch & cond_pass &
                       ((rn == PC_REG) | ((rm == PC_REG) & rm_valid));

    assign pc_plus1  = pc_q + AW'(1);
    assign pc_branch = pc_q + b_offset - AW'(1);
    assign pc_alias  = pc_q + (rs_used ? AW'(3) : AW'(2));

    // Pointer arithmetic modulo RAS_DEPTH, which need not be a power of two.
    always_comb begin
        ptr_inc = wr_ptr_q + PW'(1);
        ptr_dec = wr_ptr_q - PW'(1);
        if (wr_ptr_q == PW'(RAS_DEPTH - 1)) begin
            ptr_inc = '0;
        end
        if (wr_ptr_q == '0) begin
            ptr_dec = PW'(RAS_DEPTH - 1);
        end
    end

    assign ras_top = ras_mem[ptr_dec];

    // RAS storage; contents are don't-care after reset so no reset is used.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_ptr_q] <= pc_plus1;
        end
    end

    // Sequencer state machine. flush is registered alongside the state so it
    // has no combinational path from the inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
            ras_count_q <= '0;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (taken) begin
                        if (ret) begin
                            // ret wins over link: no push on a return.
                            if (!ras_empty) begin
                                pc_q        <= ras_top;
                                ras_count_q <= ras_count_q - CW'(1);
                                wr_ptr_q    <= ptr_dec;
                            end else begin
                                pc_q        <= pc_plus1;
                                underflow_q <= 1'b1;
                            end
                        end else begin
                            pc_q <= pc_branch;
                            if (link) begin
                                wr_ptr_q <= ptr_inc;
                                if (!ras_full) begin
                                    ras_count_q <= ras_count_q + CW'(1);
                                end
                            end
                        end
                        if (FLUSH_CYCLES > 0) begin
                            state_q <= StFlush;
                            flush_q <= 1'b1;
                            cnt_q   <= FW'(FLUSH_CYCLES);
                        end
                    end else if (!stall) begin
                        if (alias_hit) begin
                            pc_q <= pc_alias;
                        end else begin
                            pc_q <= pc_plus1;
                        end
                    end
                end
                StFlush: begin
                    // PC holds; the countdown freezes while stalled.
                    if (!stall) begin
                        if (cnt_q == FW'(1)) begin
                            state_q <= StRun;
                            flush_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - FW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StRun;
                    flush_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign flush         = flush_q;
    assign ras_count     = ras_count_q;
    assign ret_underflow = underflow_q;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

    localparam int AW           = 16;
    localparam int RAS_DEPTH    = 4;
    localparam int FLUSH_CYCLES = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall, branch, cond_pass, link, ret, rm_valid, rs_used;
    logic [15:0] b_offset;
    logic [3:0]  rn, rm;
    logic [15:0] pc;
    logic        flush;
    logic [2:0]  ras_count;
    logic        ret_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] m_pc;
    bit          m_in_flush;
    int          m_flush_left;
    logic [15:0] m_ras[$];
    bit          m_uf;

    pc_seq #(
        .AW           (AW),
        .RAS_DEPTH    (RAS_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .PC_REG       (4'hF),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch        (branch),
        .cond_pass     (cond_pass),
        .link          (link),
        .ret           (ret),
        .b_offset      (b_offset),
        .rn            (rn),
        .rm            (rm),
        .rm_valid      (rm_valid),
        .rs_used       (rs_used),
        .pc            (pc),
        .flush         (flush),
        .ras_count     (ras_count),
        .ret_underflow (ret_underflow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc         = 16'h0000;
        m_in_flush   = 1'b0;
        m_flush_left = 0;
        m_ras.delete();
        m_uf         = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, from the current inputs.
    function automatic void model_edge();
        if (m_in_flush) begin
            if (!stall) begin
                if (m_flush_left == 1) begin
                    m_in_flush   = 1'b0;
                    m_flush_left = 0;
                end else begin
                    m_flush_left--;
                end
            end
        end else if (branch && cond_pass) begin
            if (ret) begin
                if (m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    m_pc = m_pc + 16'd1;
                    m_uf = 1'b1;
                end
            end else begin
                if (link) begin
                    if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(m_pc + 16'd1);
                end
                m_pc = m_pc + b_offset - 16'd1;
            end
            if (FLUSH_CYCLES > 0) begin
                m_in_flush   = 1'b1;
                m_flush_left = FLUSH_CYCLES;
            end
        end else if (stall) begin
            // hold
        end else if (!branch && cond_pass &&
                     (rn == 4'hF || (rm == 4'hF && rm_valid))) begin
            m_pc = m_pc + (rs_used ? 16'd3 : 16'd2);
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endfunction

    task automatic idle();
        stall = 0; branch = 0; cond_pass = 0; link = 0; ret = 0;
        b_offset = 16'h0; rn = 4'h0; rm = 4'h0; rm_valid = 0; rs_used = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    // Plain taken branch to an absolute target, then wait out the flush.
    task automatic goto(input logic [15:0] target);
        idle();
        branch = 1; cond_pass = 1;
        b_offset = target - m_pc + 16'd1;
        step();
        idle();
        for (int i = 0; i < 8 && m_in_flush; i++) step();
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_checks++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_ras_count: got %0d want 0", ras_count); end
        n_checks++; if (ret_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", ret_underflow); end
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (pc !== 16'(i)) begin n_fail++; $display("FAIL idle_count: got %h want %h", pc, 16'(i)); end
        end
    endtask

    task automatic test_branch_flush();
        idle();
        for (int i = 0; i < 64 && m_pc != 16'h0010; i++) step();
        branch = 1; cond_pass = 1; b_offset = 16'h0005;
        step();
        idle();
        n_checks++; if (pc !== 16'h0014 || flush !== 1'b1) begin n_fail++; $display("FAIL branch_target: got pc=%h flush=%b want 0014/1", pc, flush); end
        step();
        n_checks++; if (pc !== 16'h0014 || flush !== 1'b0) begin n_fail++; $display("FAIL flush_exit: got pc=%h flush=%b want 0014/0", pc, flush); end
        step();
        n_checks++; if (pc !== 16'h0015 || flush !== 1'b0) begin n_fail++; $display("FAIL after_flush: got pc=%h flush=%b want 0015/0", pc, flush); end
        // Same again with stall held during FLUSH.
        branch = 1; cond_pass = 1; b_offset = 16'h0005;
        step();
        idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc !== 16'h0019 || flush !== 1'b1) begin n_fail++; $display("FAIL stall_in_flush: got pc=%h flush=%b want 0019/1", pc, flush); end
        end
        stall = 0;
        step();
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_release: got flush=%b want 0", flush); end
        step();
        n_checks++; if (pc !== 16'h001A) begin n_fail++; $display("FAIL stall_resume: got %h want 001a", pc); end
    endtask

    task automatic test_alias();
        goto(16'h0020);
        rn = 4'hF; cond_pass = 1;
        step();
        n_checks++; if (pc !== 16'h0022) begin n_fail++; $display("FAIL alias_rn: got %h want 0022", pc); end
        rn = 4'h0; rm = 4'hF; rm_valid = 1; rs_used = 1;
        step();
        n_checks++; if (pc !== 16'h0025) begin n_fail++; $display("FAIL alias_rm_rs: got %h want 0025", pc); end
        rm_valid = 0; rs_used = 0;
        step();
        n_checks++; if (pc !== 16'h0026) begin n_fail++; $display("FAIL alias_rm_invalid: got %h want 0026", pc); end
        // Not-taken branch reading the PC is not an alias skip.
        rn = 4'hF; branch = 1; cond_pass = 0;
        step();
        n_checks++; if (pc !== 16'h0027) begin n_fail++; $display("FAIL nottaken_branch: got %h want 0027", pc); end
        idle();
        stall = 1;
        step();
        n_checks++; if (pc !== 16'h0027) begin n_fail++; $display("FAIL run_stall: got %h want 0027", pc); end
        idle();
    endtask

    task automatic test_call_return();
        goto(16'h0100);
        branch = 1; cond_pass = 1; link = 1; b_offset = 16'h0041;
        step();
        idle();
        n_checks++; if (pc !== 16'h0140 || ras_count !== 3'd1) begin n_fail++; $display("FAIL call: got pc=%h cnt=%0d want 0140/1", pc, ras_count); end
        step();
        step();
        branch = 1; cond_pass = 1; ret = 1; link = 1;
        step();
        idle();
        n_checks++; if (pc !== 16'h0101 || ras_count !== 3'd0) begin n_fail++; $display("FAIL return: got pc=%h cnt=%0d want 0101/0", pc, ras_count); end
        step();
        branch = 1; cond_pass = 1; ret = 1;
        step();
        idle();
        n_checks++; if (pc !== 16'h0102 || ret_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow: got pc=%h uf=%b want 0102/1", pc, ret_underflow); end
        step();
        step();
        n_checks++; if (pc !== 16'h0103 || ret_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got pc=%h uf=%b want 0103/1", pc, ret_underflow); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] src [5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            goto(16'h0200 + 16'(i) * 16'h0040);
            src[i] = m_pc;
            branch = 1; cond_pass = 1; link = 1; b_offset = 16'h0010;
            step();
            idle();
            step();
            n_checks++; if (ras_count !== 3'((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL overflow_count: got %0d want %0d", ras_count, (i < 4) ? i + 1 : 4); end
        end
        for (int i = 0; i < 5; i++) begin
            branch = 1; cond_pass = 1; ret = 1;
            step();
            idle();
            if (i < 4) begin
                n_checks++; if (pc !== src[4 - i] + 16'd1 || ret_underflow !== 1'b0) begin n_fail++; $display("FAIL overflow_ret: got pc=%h uf=%b want %h/0", pc, ret_underflow, src[4 - i] + 16'd1); end
            end else begin
                n_checks++; if (pc !== src[1] + 16'd2 || ret_underflow !== 1'b1) begin n_fail++; $display("FAIL overflow_underflow: got pc=%h uf=%b want %h/1", pc, ret_underflow, src[1] + 16'd2); end
            end
            n_checks++; if (ras_count !== 3'((i < 4) ? 3 - i : 0)) begin n_fail++; $display("FAIL overflow_pop_count: got %0d want %0d", ras_count, (i < 4) ? 3 - i : 0); end
            step();
        end
    endtask

    task automatic test_edges();
        goto(16'hFFFF);
        step();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h want 0000", pc); end
        goto(16'h0005);
        branch = 1; cond_pass = 1; b_offset = 16'hFFF0;
        step();
        idle();
        n_checks++; if (pc !== 16'hFFF4 || flush !== 1'b1) begin n_fail++; $display("FAIL neg_offset: got pc=%h flush=%b want fff4/1", pc, flush); end
        // Asynchronous reset mid-FLUSH, between clock edges.
        reset_n = 1'b0;
        #1;
        n_checks++; if (pc !== 16'h0000 || flush !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc=%h flush=%b want 0000/0", pc, flush); end
        n_checks++; if (ret_underflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_uf: got %b want 0", ret_underflow); end
        model_reset();
        #1;
        reset_n = 1'b1;
        step();
        n_checks++; if (pc !== 16'h0001 || flush !== 1'b0) begin n_fail++; $display("FAIL after_async_reset: got pc=%h flush=%b want 0001/0", pc, flush); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            stall     = ($urandom % 4) == 0;
            branch    = ($urandom % 4) == 0;
            cond_pass = ($urandom % 3) != 0;
            link      = $urandom % 2;
            ret       = ($urandom % 3) == 0;
            b_offset  = 16'($urandom);
            rn        = (($urandom % 4) == 0) ? 4'hF : 4'($urandom);
            rm        = (($urandom % 4) == 0) ? 4'hF : 4'($urandom);
            rm_valid  = $urandom % 2;
            rs_used   = $urandom % 2;
            step();
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", c, pc, m_pc); end
            n_checks++; if (flush !== m_in_flush) begin n_fail++; $display("FAIL rand_flush[%0d]: got %b want %b", c, flush, m_in_flush); end
            n_checks++; if (ras_count !== 3'(m_ras.size())) begin n_fail++; $display("FAIL rand_ras_count[%0d]: got %0d want %0d", c, ras_count, m_ras.size()); end
            n_checks++; if (ret_underflow !== m_uf) begin n_fail++; $display("FAIL rand_underflow[%0d]: got %b want %b", c, ret_underflow, m_uf); end
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_branch_flush();
        test_alias();
        test_call_return();
        test_ras_overflow();
        test_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Registered program-counter sequencer for the fetch stage. It is the parametrised successor of the combinational PC-next unit. It adds:
- configurable address width,
- a configurable branch-shadow flush length,
- a return-address stack (RAS) for branch-and-link and return.

It sits between the decode/condition logic and the instruction memory address port, and drives the fetch address every cycle.

Parameters:
AW, 16, width of PC, offset and return addresses
RAS_DEPTH, 4, return-address stack entries (>=1)
FLUSH_CYCLES, 1, bubble cycles after a taken branch (0 = no flush state)
PC_REG, 4'hF, register index that aliases the PC
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active-low
stall  in  1  hold PC (pipeline stall)
branch  in  1  current instruction is a branch
cond_pass  in  1  condition code of current instruction passes
link  in  1  branch also pushes return address (with branch)
ret  in  1  branch target is RAS top (with branch)
b_offset  in  AW  two's-complement branch offset
rn  in  4  first source register index
rm  in  4  second source register index
rm_valid  in  1  rm field is a real register operand
rs_used  in  1  instruction carries an extra shift-register word
pc  out  AW  registered fetch address
flush  out  1  high while in FLUSH; downstream squashes fetched word
ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
ret_underflow  out  1  sticky: ret executed with empty RAS

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_PC, state=RUN, flush=0, ras_count=0, ret_underflow=0, flush counter=0.
  - Reset mid-FLUSH aborts the flush immediately.
  - RAS contents are don't-care after reset.
- All arithmetic is modulo 2^AW; wrap-around is silent.
- States: RUN, FLUSH. State and pc are updated on the clk rising edge only.
- taken = branch & cond_pass. Decisions are evaluated only in RUN.
- RUN priority, highest first:
  1. taken & ret, RAS non-empty: pc <= RAS top; pop (ras_count-1).
  2. taken & ret, RAS empty: pc <= pc+1; set ret_underflow; no pop.
  3. taken & !ret: pc <= pc + b_offset - 1. If link, push pc+1 (the value before update).
  4. stall (not taken): pc holds.
  5. !branch & cond_pass & (rn==PC_REG | (rm==PC_REG & rm_valid)): pc <= pc + (rs_used ? 3 : 2).
  6. Otherwise: pc <= pc+1.
- Taken branch beats stall.
- Any taken branch, including the underflow case, enters FLUSH if FLUSH_CYCLES>0. It loads counter=FLUSH_CYCLES; otherwise it stays in RUN.
- FLUSH:
  - flush=1 and pc holds.
  - branch, link, ret and the operand-alias inputs are ignored.
  - counter decrements each cycle stall=0 and freezes while stall=1.
  - Counter==1 with stall=0 returns to RUN next cycle; flush=0 from that cycle.
- RAS push when ras_count==RAS_DEPTH overwrites the oldest entry (circular); ras_count stays RAS_DEPTH.
- link & ret together: ret takes effect; no push.
- link without taken branch: ignored.
- ret_underflow clears only on reset.
- flush is registered (state-decoded), with no combinational path from inputs.

Test Plan:
1. Reset: hold reset_n=0, then release. pc=0, flush=0, ras_count=0. Idle inputs give pc 0,1,2,3 on successive edges.
2. Taken branch, FLUSH_CYCLES=1: at pc=0x0010 drive branch=1, cond_pass=1, b_offset=0x0005. Next edge pc=0x0014 with flush=1 for one cycle, then pc=0x0015, flush=0. Repeat with stall=1 during FLUSH: flush is held for those cycles.
3. PC alias: at pc=0x0020 drive rn=4'hF, cond_pass=1 → pc=0x0022. Then rm=4'hF, rm_valid=1, rs_used=1 → pc=0x0025. rm=4'hF with rm_valid=0 → pc=0x0026.
4. Call/return: at pc=0x0100 drive link branch with b_offset=0x0041 → pc=0x0140, ras_count=1. Later ret branch → pc=0x0101, ras_count=0. A second ret → pc increments by 1, ret_underflow=1 (sticky).
5. RAS overflow, RAS_DEPTH=4: perform 5 link calls from pc values A..E. ras_count stays 4. Five rets return E, D, C, B, then underflow.
6. Edge cases:
   - Wrap: pc=0xFFFF with idle inputs → 0x0000.
   - Branch with b_offset=0xFFF0 at pc=0x0005 → pc=0xFFF4.
   - Assert reset_n=0 mid-FLUSH between edges → pc=RESET_PC and flush=0 immediately, without waiting for a clock edge.
